seq_pattern_gen: RTL and testbench

//  Upstream stimulus stage for the serial sequence detector. Loads a parallel

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_pattern_gen.sv | 129 ++++++++++++
 tb/tb_seq_pattern_gen.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: state encodings and default sizing.
package seq_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned LEN_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : seq_pkg

// File: rtl/seq_pattern_gen.sv
// Parallel-to-serial pattern generator: emits bits [len-1:0] of a captured pattern MSB first,
// with single-shot or continuous-repeat mode, abort, and done/err pulses.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic             stop,
  input  logic             rep,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] data,
  output logic             d_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] bit_cnt
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_n;
  logic [WIDTH-1:0]   pat, pat_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic               rep_q, rep_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               d_out_n, valid_n, busy_n, done_n, err_n;
  logic [LEN_W-1:0]   bit_cnt_n;
  logic               len_ok_c;

  assign len_ok_c = (len != '0) && (len <= LEN_W'(WIDTH));

  // State, captured frame and registered outputs
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state   <= ST_IDLE;
      pat     <= '0;
      len_q   <= '0;
      rep_q   <= 1'b0;
      idx     <= '0;
      d_out   <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      pat     <= pat_n;
      len_q   <= len_n;
      rep_q   <= rep_n;
      idx     <= idx_n;
      d_out   <= d_out_n;
      valid   <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
      bit_cnt <= bit_cnt_n;
    end
  end

  // Next-state and next-output logic; idx walks the pattern down instead of shifting it
  always_comb begin
    state_n   = state;
    pat_n     = pat;
    len_n     = len_q;
    rep_n     = rep_q;
    idx_n     = idx;
    d_out_n   = 1'b0;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    bit_cnt_n = bit_cnt;

    case (state)
      ST_IDLE: begin
        bit_cnt_n = '0;
        if (start && !stop) begin
          if (len_ok_c) begin
            pat_n   = data;
            len_n   = len;
            rep_n   = rep;
            idx_n   = IDX_W'(len - LEN_W'(1));
            state_n = ST_SHIFT;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (stop) begin
          state_n   = ST_IDLE;
          bit_cnt_n = '0;
        end else begin
          d_out_n   = pat[idx];
          valid_n   = 1'b1;
          // Count restarts on the first bit of each repeated frame
          bit_cnt_n = (bit_cnt == len_q) ? LEN_W'(1) : bit_cnt + LEN_W'(1);
          if (idx != '0) begin
            idx_n = idx - IDX_W'(1);
          end else if (rep_q) begin
            idx_n = IDX_W'(len_q - LEN_W'(1));
          end else begin
            state_n = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_n    = 1'b1;
        bit_cnt_n = '0;
        state_n   = ST_IDLE;
      end

      default: begin
        state_n   = ST_IDLE;
        bit_cnt_n = '0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule : seq_pattern_gen

// File: tb/tb_seq_pattern_gen.sv
// Directed self-checking bench for seq_pattern_gen (WIDTH=8, LEN_W=6).
module tb_seq_pattern_gen;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 6;

  logic             clk = 1'b0;
  logic             r = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             rep = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [WIDTH-1:0] data = '0;
  logic             d_out, valid, busy, done, err;
  logic [LEN_W-1:0] bit_cnt;
  logic [4:0]       flags;

  int checks = 0;
  int errors = 0;

  assign flags = {valid, d_out, busy, done, err};

  seq_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .r(r), .start(start), .stop(stop), .rep(rep), .len(len), .data(data),
    .d_out(d_out), .valid(valid), .busy(busy), .done(done), .err(err), .bit_cnt(bit_cnt)
  );

  always #2 clk = ~clk;

  // Inputs are driven and outputs sampled at the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if (flags !== 5'b0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL reset: flags=%b bit_cnt=%0d, expected flags=00000 bit_cnt=0", flags, bit_cnt);
    end
    r = 1'b1;
    step();
    checks++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL reset_release: flags=%b expected 00000", flags);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] pat;
    pat = 8'b1010_1101;
    data = pat; len = 6'd8; rep = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (flags !== 5'b00100) begin
      errors++;
      $display("FAIL single_accept: flags=%b expected 00100", flags);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (flags !== {1'b1, pat[7-i], 3'b100} || bit_cnt !== 6'(i + 1)) begin
        errors++;
        $display("FAIL single_bit%0d: flags=%b bit_cnt=%0d expected flags=%b bit_cnt=%0d",
                 i, flags, bit_cnt, {1'b1, pat[7-i], 3'b100}, i + 1);
      end
    end
    step();
    checks++;
    if (flags !== 5'b00010 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL single_done: flags=%b bit_cnt=%0d expected flags=00010 bit_cnt=0", flags, bit_cnt);
    end
    step();
    checks++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL single_after: flags=%b expected 00000", flags);
    end
  endtask

  task automatic test_short();
    logic [2:0] exp_bits;
    int ndone;
    exp_bits = 3'b110;
    ndone = 0;
    data = 8'b1111_1110; len = 6'd3; rep = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || d_out !== exp_bits[2-i] || bit_cnt !== 6'(i + 1)) begin
        errors++;
        $display("FAIL short_bit%0d: valid=%b d_out=%b bit_cnt=%0d expected 1 %b %0d",
                 i, valid, d_out, bit_cnt, exp_bits[2-i], i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL short_done_count: got %0d pulses expected 1", ndone);
    end
  endtask

  task automatic test_repeat();
    logic [3:0] pat;
    pat = 4'b1011;
    data = {4'b0, pat}; len = 6'd4; rep = 1'b1; start = 1'b1;
    step();
    start = 1'b0; data = 8'h00; rep = 1'b0; len = 6'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (flags !== {1'b1, pat[3 - (i % 4)], 3'b100} || bit_cnt !== 6'((i % 4) + 1)) begin
        errors++;
        $display("FAIL repeat_bit%0d: flags=%b bit_cnt=%0d expected flags=%b bit_cnt=%0d",
                 i, flags, bit_cnt, {1'b1, pat[3 - (i % 4)], 3'b100}, (i % 4) + 1);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (flags !== 5'b0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL repeat_stop: flags=%b bit_cnt=%0d expected flags=00000 bit_cnt=0", flags, bit_cnt);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL repeat_no_done: done=%b expected 0", done);
    end
  endtask

  task automatic test_illegal();
    data = 8'hFF; rep = 1'b0;
    len = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (flags !== 5'b00001) begin
      errors++;
      $display("FAIL illegal_len0: flags=%b expected 00001", flags);
    end
    step();
    checks++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL illegal_len0_clear: flags=%b expected 00000", flags);
    end
    len = 6'd9; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (flags !== 5'b00001) begin
      errors++;
      $display("FAIL illegal_len9: flags=%b expected 00001", flags);
    end
    step();
    checks++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL illegal_len9_clear: flags=%b expected 00000", flags);
    end
  endtask

  task automatic test_busy_start();
    logic [3:0] pat;
    pat = 4'b1001;
    data = {4'b0, pat}; len = 6'd4; rep = 1'b0; start = 1'b1;
    step();
    // Keep start high with a different, illegal request while busy
    data = 8'hFF; len = 6'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (flags !== {1'b1, pat[3-i], 3'b100}) begin
        errors++;
        $display("FAIL busy_bit%0d: flags=%b expected %b", i, flags, {1'b1, pat[3-i], 3'b100});
      end
    end
    start = 1'b0;
    step();
    checks++;
    if (flags !== 5'b00010) begin
      errors++;
      $display("FAIL busy_done: flags=%b expected 00010", flags);
    end
    start = 1'b1; stop = 1'b1; len = 6'd0;
    step();
    checks++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL stop_wins_illegal: flags=%b expected 00000", flags);
    end
    len = 6'd4;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    checks++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL stop_wins_legal: flags=%b expected 00000", flags);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] pat;
    data = 8'hA5; len = 6'd8; rep = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    r = 1'b0;
    #1;
    checks++;
    if (flags !== 5'b0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: flags=%b bit_cnt=%0d expected flags=00000 bit_cnt=0", flags, bit_cnt);
    end
    step();
    r = 1'b1;
    step();
    pat = 8'h3C;
    data = pat; len = 6'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (flags !== {1'b1, pat[7-i], 3'b100} || bit_cnt !== 6'(i + 1)) begin
        errors++;
        $display("FAIL post_reset_bit%0d: flags=%b bit_cnt=%0d expected flags=%b bit_cnt=%0d",
                 i, flags, bit_cnt, {1'b1, pat[7-i], 3'b100}, i + 1);
      end
    end
    step();
    checks++;
    if (flags !== 5'b00010) begin
      errors++;
      $display("FAIL post_reset_done: flags=%b expected 00010", flags);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_short();
    test_repeat();
    test_illegal();
    test_busy_start();
    test_async_reset();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_pattern_gen
